// File: rtl/axi4_lite_defs.sv
// -----------------------------------------------------------------------------
// axi4_lite_defs
// Shared AXI4-Lite definitions: bus widths, response codes and the state
// encodings used by the register slave's write and read channel FSMs.
// No ports (package).
// -----------------------------------------------------------------------------
package axi4_lite_defs;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Write channel: which half of the AW/W pair has been captured so far,
    // or waiting for the master to take the B response.
    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_HAVE_AW = 2'd1,
        WR_HAVE_W  = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_t;

endpackage

// File: rtl/axi4_lite_strb_merge.sv
// -----------------------------------------------------------------------------
// axi4_lite_strb_merge
// Combinational byte-lane merge: each byte of the result comes from new_data
// when its strobe bit is set, otherwise from old_data.
// Ports:
//   old_data  in  32  current register contents
//   new_data  in  32  incoming write data
//   strb      in  4   byte-lane enables
//   merged    out 32  merged result
// -----------------------------------------------------------------------------
module axi4_lite_strb_merge
    import axi4_lite_defs::*;
(
    input  logic [AXI_DATA_W-1:0] old_data,
    input  logic [AXI_DATA_W-1:0] new_data,
    input  logic [AXI_STRB_W-1:0] strb,
    output logic [AXI_DATA_W-1:0] merged
);

    always_comb begin
        merged = old_data;
        for (int b = 0; b < AXI_STRB_W; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_data[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// axi4_lite_reg_slave
// AXI4-Lite responder exposing NUM_REGS 32-bit registers. Registers
// 0..NUM_REGS-2 are read/write and appear on oREGS; the last register is
// read-only and returns iSTATUS. One write and one read may be outstanding.
// Ports:
//   iCLK, iRST          clock (rising edge), async active-low reset
//   s_AW*/s_W*/s_B*     AXI4-Lite write address, data and response channels
//   s_AR*/s_R*          AXI4-Lite read address and data channels
//   iSTATUS       in 32 value returned by the read-only register
//   oREGS         out   flattened R/W registers, reg i at [32*i+31:32*i],
//                       last slot tied to 0
// -----------------------------------------------------------------------------
module axi4_lite_reg_slave
    import axi4_lite_defs::*;
#(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                     iCLK,
    input  logic                     iRST,
    input  logic                     s_AWVALID,
    output logic                     s_AWREADY,
    input  logic [AXI_ADDR_W-1:0]    s_AWADDR,
    input  logic [2:0]               s_AWPROT,
    input  logic                     s_WVALID,
    output logic                     s_WREADY,
    input  logic [AXI_DATA_W-1:0]    s_WDATA,
    input  logic [AXI_STRB_W-1:0]    s_WSTRB,
    output logic                     s_BVALID,
    input  logic                     s_BREADY,
    output logic [1:0]               s_BRESP,
    input  logic                     s_ARVALID,
    output logic                     s_ARREADY,
    input  logic [AXI_ADDR_W-1:0]    s_ARADDR,
    input  logic [2:0]               s_ARPROT,
    output logic                     s_RVALID,
    input  logic                     s_RREADY,
    output logic [AXI_DATA_W-1:0]    s_RDATA,
    output logic [1:0]               s_RRESP,
    input  logic [AXI_DATA_W-1:0]    iSTATUS,
    output logic [32*NUM_REGS-1:0]   oREGS
);

    localparam logic [AXI_ADDR_W-1:0] SPAN   = AXI_ADDR_W'(NUM_REGS * 4);
    localparam logic [IDX_W-1:0]      RO_IDX = IDX_W'(NUM_REGS - 1);

    logic                  enable;
    wr_state_t             wr_state, wr_next;
    rd_state_t             rd_state, rd_next;
    logic                  aw_full, w_full;
    logic                  aw_hs, w_hs, ar_hs, commit;

    logic [AXI_ADDR_W-1:0] aw_addr_q;
    logic [AXI_DATA_W-1:0] w_data_q;
    logic [AXI_STRB_W-1:0] w_strb_q;
    logic [AXI_DATA_W-1:0] regs [NUM_REGS];

    logic [AXI_ADDR_W-1:0] commit_addr, commit_off;
    logic [AXI_DATA_W-1:0] commit_data, merged;
    logic [AXI_STRB_W-1:0] commit_strb;
    logic [IDX_W-1:0]      commit_idx;
    logic                  commit_hit, commit_ok;

    logic [AXI_ADDR_W-1:0] rd_off;
    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_hit;

    logic                  unused_ok;
    assign unused_ok = ^{s_AWPROT, s_ARPROT, commit_off[1:0], rd_off[1:0]};

    assign aw_hs = s_AWVALID & s_AWREADY;
    assign w_hs  = s_WVALID  & s_WREADY;
    assign ar_hs = s_ARVALID & s_ARREADY;

    // Whichever half of the write arrived earlier comes from its capture
    // register; the half arriving on the commit edge comes straight off the bus.
    assign commit_addr = aw_full ? aw_addr_q : s_AWADDR;
    assign commit_data = w_full  ? w_data_q  : s_WDATA;
    assign commit_strb = w_full  ? w_strb_q  : s_WSTRB;

    assign commit_off = commit_addr - BASE_ADDR;
    assign commit_hit = commit_off < SPAN;
    assign commit_idx = commit_off[IDX_W+1:2];
    assign commit_ok  = commit_hit && (commit_idx != RO_IDX);

    assign rd_off = s_ARADDR - BASE_ADDR;
    assign rd_hit = rd_off < SPAN;
    assign rd_idx = rd_off[IDX_W+1:2];

    axi4_lite_strb_merge u_merge (
        .old_data (regs[commit_idx]),
        .new_data (commit_data),
        .strb     (commit_strb),
        .merged   (merged)
    );

    // Readies stay low until the first edge after reset release.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            enable   <= 1'b0;
            wr_state <= WR_IDLE;
            rd_state <= RD_IDLE;
        end else begin
            enable   <= 1'b1;
            wr_state <= wr_next;
            rd_state <= rd_next;
        end
    end

    always_comb begin
        wr_next = wr_state;
        commit  = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit  = 1'b1;
                    wr_next = WR_RESP;
                end else if (aw_hs) begin
                    wr_next = WR_HAVE_AW;
                end else if (w_hs) begin
                    wr_next = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                if (w_hs) begin
                    commit  = 1'b1;
                    wr_next = WR_RESP;
                end
            end
            WR_HAVE_W: begin
                if (aw_hs) begin
                    commit  = 1'b1;
                    wr_next = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_BREADY) begin
                    wr_next = WR_IDLE;
                end
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE: if (ar_hs)    rd_next = RD_RESP;
            RD_RESP: if (s_RREADY) rd_next = RD_IDLE;
            default: rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        aw_full   = (wr_state == WR_HAVE_AW);
        w_full    = (wr_state == WR_HAVE_W);
        s_BVALID  = (wr_state == WR_RESP);
        s_AWREADY = enable & ~aw_full & ~s_BVALID;
        s_WREADY  = enable & ~w_full  & ~s_BVALID;
        s_RVALID  = (rd_state == RD_RESP);
        s_ARREADY = enable & ~s_RVALID;
    end

    // Write capture, register array and B response code. The read-only slot
    // is never written, so it stays at zero and oREGS ties it off naturally.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            s_BRESP   <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (aw_hs) aw_addr_q <= s_AWADDR;
            if (w_hs) begin
                w_data_q <= s_WDATA;
                w_strb_q <= s_WSTRB;
            end
            if (commit) begin
                s_BRESP <= commit_ok ? RESP_OKAY : RESP_SLVERR;
                if (commit_ok) regs[commit_idx] <= merged;
            end
        end
    end

    // Read data is sampled on the AR handshake edge, so a write committing on
    // the same edge is not yet visible.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            s_RDATA <= '0;
            s_RRESP <= RESP_OKAY;
        end else if (ar_hs) begin
            if (!rd_hit) begin
                s_RDATA <= '0;
                s_RRESP <= RESP_SLVERR;
            end else if (rd_idx == RO_IDX) begin
                s_RDATA <= iSTATUS;
                s_RRESP <= RESP_OKAY;
            end else begin
                s_RDATA <= regs[rd_idx];
                s_RRESP <= RESP_OKAY;
            end
        end
    end

    always_comb begin
        oREGS = '0;
        for (int i = 0; i < NUM_REGS - 1; i++) begin
            oREGS[32*i +: 32] = regs[i];
        end
    end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// -----------------------------------------------------------------------------
// tb_axi4_lite_reg_slave
// Directed self-checking bench for axi4_lite_reg_slave (NUM_REGS = 8,
// BASE_ADDR = 0x4000_0000). Inputs change and outputs are sampled 1 ns after
// each rising clock edge.
// -----------------------------------------------------------------------------
module tb_axi4_lite_reg_slave;

    logic         iCLK = 1'b0;
    logic         iRST = 1'b0;
    logic         s_AWVALID = 1'b0, s_AWREADY;
    logic [31:0]  s_AWADDR = '0;
    logic [2:0]   s_AWPROT = '0;
    logic         s_WVALID = 1'b0, s_WREADY;
    logic [31:0]  s_WDATA = '0;
    logic [3:0]   s_WSTRB = '0;
    logic         s_BVALID, s_BREADY = 1'b0;
    logic [1:0]   s_BRESP;
    logic         s_ARVALID = 1'b0, s_ARREADY;
    logic [31:0]  s_ARADDR = '0;
    logic [2:0]   s_ARPROT = '0;
    logic         s_RVALID, s_RREADY = 1'b0;
    logic [31:0]  s_RDATA;
    logic [1:0]   s_RRESP;
    logic [31:0]  iSTATUS = '0;
    logic [255:0] oREGS;

    int errors = 0;
    int checks = 0;

    axi4_lite_reg_slave dut (
        .iCLK(iCLK), .iRST(iRST),
        .s_AWVALID(s_AWVALID), .s_AWREADY(s_AWREADY), .s_AWADDR(s_AWADDR), .s_AWPROT(s_AWPROT),
        .s_WVALID(s_WVALID), .s_WREADY(s_WREADY), .s_WDATA(s_WDATA), .s_WSTRB(s_WSTRB),
        .s_BVALID(s_BVALID), .s_BREADY(s_BREADY), .s_BRESP(s_BRESP),
        .s_ARVALID(s_ARVALID), .s_ARREADY(s_ARREADY), .s_ARADDR(s_ARADDR), .s_ARPROT(s_ARPROT),
        .s_RVALID(s_RVALID), .s_RREADY(s_RREADY), .s_RDATA(s_RDATA), .s_RRESP(s_RRESP),
        .iSTATUS(iSTATUS), .oREGS(oREGS)
    );

    always #5 iCLK = ~iCLK;

    task automatic stepCycle();
        @(posedge iCLK);
        #1;
    endtask

    // Full write with a bounded wait for the B response.
    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp,
                            output logic timedOut);
        logic awAcc, wAcc;
        timedOut  = 1'b1;
        resp      = 2'bxx;
        s_AWADDR  = addr;
        s_WDATA   = data;
        s_WSTRB   = strb;
        s_AWVALID = 1'b1;
        s_WVALID  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            awAcc = s_AWVALID & s_AWREADY;
            wAcc  = s_WVALID & s_WREADY;
            stepCycle();
            if (awAcc) s_AWVALID = 1'b0;
            if (wAcc)  s_WVALID  = 1'b0;
            if (s_BVALID) begin
                timedOut = 1'b0;
                break;
            end
        end
        s_AWVALID = 1'b0;
        s_WVALID  = 1'b0;
        resp      = s_BRESP;
        s_BREADY  = 1'b1;
        stepCycle();
        s_BREADY  = 1'b0;
    endtask

    // Full read with a bounded wait for the R response.
    task automatic busRead(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output logic timedOut);
        logic arAcc;
        timedOut  = 1'b1;
        data      = 'x;
        resp      = 2'bxx;
        s_ARADDR  = addr;
        s_ARVALID = 1'b1;
        for (int c = 0; c < 20; c++) begin
            arAcc = s_ARVALID & s_ARREADY;
            stepCycle();
            if (arAcc) s_ARVALID = 1'b0;
            if (s_RVALID) begin
                timedOut = 1'b0;
                break;
            end
        end
        s_ARVALID = 1'b0;
        data      = s_RDATA;
        resp      = s_RRESP;
        s_RREADY  = 1'b1;
        stepCycle();
        s_RREADY  = 1'b0;
    endtask

    task automatic test_reset();
        iRST = 1'b0;
        #2;
        checks++;
        if ({s_AWREADY, s_WREADY, s_ARREADY, s_BVALID, s_RVALID} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_handshake: got %b expected 00000",
                     {s_AWREADY, s_WREADY, s_ARREADY, s_BVALID, s_RVALID});
        end
        stepCycle();
        stepCycle();
        checks++;
        if ({s_BRESP, s_RRESP, s_RDATA, oREGS} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got bresp=%b rresp=%b rdata=%h oregs=%h expected all 0",
                     s_BRESP, s_RRESP, s_RDATA, oREGS);
        end
        @(negedge iCLK);
        iRST = 1'b1;
        #1;
        checks++;
        if ({s_AWREADY, s_WREADY, s_ARREADY} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL ready_before_edge: got %b expected 000",
                     {s_AWREADY, s_WREADY, s_ARREADY});
        end
        stepCycle();
        checks++;
        if ({s_AWREADY, s_WREADY, s_ARREADY} !== 3'b111) begin
            errors++;
            $display("[TB] FAIL ready_after_edge: got %b expected 111",
                     {s_AWREADY, s_WREADY, s_ARREADY});
        end
    endtask

    task automatic test_write_same_cycle();
        logic [31:0] rdData;
        logic [1:0]  rdResp;
        logic        tmo;
        s_AWADDR  = 32'h4000_0004;
        s_WDATA   = 32'hDEAD_BEEF;
        s_WSTRB   = 4'b1111;
        s_AWVALID = 1'b1;
        s_WVALID  = 1'b1;
        stepCycle();
        s_AWVALID = 1'b0;
        s_WVALID  = 1'b0;
        checks++;
        if ({s_BVALID, s_BRESP} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL same_cycle_b: got bvalid=%b bresp=%b expected 1/00", s_BVALID, s_BRESP);
        end
        checks++;
        if (oREGS[63:32] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL same_cycle_reg1: got %h expected deadbeef", oREGS[63:32]);
        end
        s_BREADY = 1'b1;
        stepCycle();
        s_BREADY = 1'b0;
        checks++;
        if ({s_BVALID, s_AWREADY, s_WREADY} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL b_release: got bvalid/awready/wready=%b expected 011",
                     {s_BVALID, s_AWREADY, s_WREADY});
        end
        busRead(32'h4000_0004, rdData, rdResp, tmo);
        checks++;
        if ({tmo, rdResp, rdData} !== {1'b0, 2'b00, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL read_reg1: got tmo=%b rresp=%b rdata=%h expected 0/00/deadbeef",
                     tmo, rdResp, rdData);
        end
    endtask

    task automatic test_w_before_aw();
        s_WDATA  = 32'h1122_3344;
        s_WSTRB  = 4'b0101;
        s_WVALID = 1'b1;
        stepCycle();
        s_WVALID = 1'b0;
        checks++;
        if ({s_WREADY, s_AWREADY, s_BVALID} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL w_captured: got wready/awready/bvalid=%b expected 010",
                     {s_WREADY, s_AWREADY, s_BVALID});
        end
        stepCycle();
        stepCycle();
        checks++;
        if ({s_BVALID, oREGS[63:32]} !== {1'b0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("[TB] FAIL w_waiting: got bvalid=%b reg1=%h expected 0/deadbeef",
                     s_BVALID, oREGS[63:32]);
        end
        s_AWADDR  = 32'h4000_0004;
        s_AWVALID = 1'b1;
        stepCycle();
        s_AWVALID = 1'b0;
        checks++;
        if ({s_BVALID, s_BRESP, oREGS[63:32]} !== {1'b1, 2'b00, 32'hDE22_BE44}) begin
            errors++;
            $display("[TB] FAIL strobe_merge: got bvalid=%b bresp=%b reg1=%h expected 1/00/de22be44",
                     s_BVALID, s_BRESP, oREGS[63:32]);
        end
        s_BREADY = 1'b1;
        stepCycle();
        s_BREADY = 1'b0;
    endtask

    task automatic test_errors();
        logic [31:0] rdData;
        logic [1:0]  resp;
        logic        tmo;
        busWrite(32'h4000_001C, 32'hFFFF_FFFF, 4'b1111, resp, tmo);
        checks++;
        if ({tmo, resp, oREGS[255:224], oREGS[63:32]} !== {1'b0, 2'b10, 32'h0, 32'hDE22_BE44}) begin
            errors++;
            $display("[TB] FAIL write_readonly: got tmo=%b bresp=%b slot7=%h reg1=%h expected 0/10/0/de22be44",
                     tmo, resp, oREGS[255:224], oREGS[63:32]);
        end
        busWrite(32'h4000_0020, 32'h1234_5678, 4'b1111, resp, tmo);
        checks++;
        if ({tmo, resp} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL write_miss: got tmo=%b bresp=%b expected 0/10", tmo, resp);
        end
        iSTATUS = 32'hA5A5_0001;
        busRead(32'h4000_001C, rdData, resp, tmo);
        checks++;
        if ({tmo, resp, rdData} !== {1'b0, 2'b00, 32'hA5A5_0001}) begin
            errors++;
            $display("[TB] FAIL read_status: got tmo=%b rresp=%b rdata=%h expected 0/00/a5a50001",
                     tmo, resp, rdData);
        end
        busRead(32'h4000_0040, rdData, resp, tmo);
        checks++;
        if ({tmo, resp, rdData} !== {1'b0, 2'b10, 32'h0}) begin
            errors++;
            $display("[TB] FAIL read_miss: got tmo=%b rresp=%b rdata=%h expected 0/10/0",
                     tmo, resp, rdData);
        end
    endtask

    task automatic test_backpressure();
        s_AWADDR  = 32'h4000_000C;
        s_WDATA   = 32'h1234_5678;
        s_WSTRB   = 4'b1111;
        s_ARADDR  = 32'h4000_0004;
        s_AWVALID = 1'b1;
        s_WVALID  = 1'b1;
        s_ARVALID = 1'b1;
        stepCycle();
        s_ARVALID = 1'b0;
        s_AWADDR  = 32'h4000_0010;
        s_WDATA   = 32'hCAFE_F00D;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({s_BVALID, s_BRESP, s_RVALID, s_RRESP, s_RDATA, s_AWREADY, s_ARREADY, s_WREADY}
                !== {1'b1, 2'b00, 1'b1, 2'b00, 32'hDE22_BE44, 3'b000}) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d: got b=%b/%b r=%b/%b/%h awr=%b arr=%b wr=%b expected 1/00 1/00/de22be44 0 0 0",
                         c, s_BVALID, s_BRESP, s_RVALID, s_RRESP, s_RDATA, s_AWREADY, s_ARREADY, s_WREADY);
            end
            stepCycle();
        end
        checks++;
        if ({oREGS[127:96], oREGS[159:128]} !== {32'h1234_5678, 32'h0}) begin
            errors++;
            $display("[TB] FAIL held_regs: got reg3=%h reg4=%h expected 12345678/0",
                     oREGS[127:96], oREGS[159:128]);
        end
        s_BREADY = 1'b1;
        s_RREADY = 1'b1;
        stepCycle();
        s_BREADY = 1'b0;
        s_RREADY = 1'b0;
        checks++;
        if ({s_BVALID, s_RVALID, s_AWREADY, s_ARREADY, oREGS[159:128]} !== {4'b0011, 32'h0}) begin
            errors++;
            $display("[TB] FAIL release: got bv=%b rv=%b awr=%b arr=%b reg4=%h expected 0/0/1/1/0",
                     s_BVALID, s_RVALID, s_AWREADY, s_ARREADY, oREGS[159:128]);
        end
        stepCycle();
        s_AWVALID = 1'b0;
        s_WVALID  = 1'b0;
        checks++;
        if ({s_BVALID, s_BRESP, oREGS[159:128]} !== {1'b1, 2'b00, 32'hCAFE_F00D}) begin
            errors++;
            $display("[TB] FAIL second_write: got bvalid=%b bresp=%b reg4=%h expected 1/00/cafef00d",
                     s_BVALID, s_BRESP, oREGS[159:128]);
        end
        s_BREADY = 1'b1;
        stepCycle();
        s_BREADY = 1'b0;
    endtask

    task automatic test_back_to_back();
        s_AWADDR  = 32'h4000_0008;
        s_WDATA   = 32'h0000_0055;
        s_WSTRB   = 4'b1111;
        s_ARADDR  = 32'h4000_0008;
        s_AWVALID = 1'b1;
        s_WVALID  = 1'b1;
        s_ARVALID = 1'b1;
        stepCycle();
        s_AWVALID = 1'b0;
        s_WVALID  = 1'b0;
        s_ARVALID = 1'b0;
        checks++;
        if ({s_RVALID, s_RDATA, s_BVALID, oREGS[95:64]} !== {1'b1, 32'h0, 1'b1, 32'h55}) begin
            errors++;
            $display("[TB] FAIL read_during_write: got rv=%b rdata=%h bv=%b reg2=%h expected 1/0/1/55",
                     s_RVALID, s_RDATA, s_BVALID, oREGS[95:64]);
        end
        iRST = 1'b0;
        #1;
        checks++;
        if ({s_BVALID, s_RVALID, s_AWREADY, s_ARREADY, oREGS} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got bv=%b rv=%b awr=%b arr=%b oregs=%h expected all 0",
                     s_BVALID, s_RVALID, s_AWREADY, s_ARREADY, oREGS);
        end
        @(negedge iCLK);
        iRST = 1'b1;
        stepCycle();
        checks++;
        if ({s_AWREADY, s_WREADY, s_ARREADY, s_BVALID} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL after_reset: got %b expected 1110",
                     {s_AWREADY, s_WREADY, s_ARREADY, s_BVALID});
        end
    endtask

    initial begin
        $display("[TB] starting axi4_lite_reg_slave bench");
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_errors();
        test_backpressure();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
